imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port, byte-addressed 512-byte instruction memory between two requesters: the core fetch unit (read-only) and the program loader/debug port (read/write).
- Sequences every access as issue then response, arbitrates round-robin, and supports a bounded loader lock for burst program loads.
- Sits between the fetch stage / loader and the instruction memory macro. The memory macro reads synchronously and writes at the clock edge while mem_en and mem_we are both high.

Parameters:
- ADDR_W, 32, width of requester and memory byte addresses
- MEM_BYTES, 512, memory size in bytes; addresses at or above MEM_BYTES-3 are out of range
- LOCK_MAX, 16, maximum consecutive loader grants under ld_lock before a forced yield to a pending fetch

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch byte address
- if_ack  out  1  one-cycle response pulse
- if_rdata  out  32  fetch word; valid only while if_ack=1
- if_err  out  1  error qualifier; valid with if_ack
- ld_req  in  1  loader request; held with its operands until ld_ack
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_W  loader byte address
- ld_wdata  in  32  loader write word, big-endian byte order
- ld_lock  in  1  keep the grant on the loader across consecutive requests
- ld_ack  out  1  one-cycle response pulse
- ld_rdata  out  32  loader read word; valid only while ld_ack=1
- ld_err  out  1  error qualifier; valid with ld_ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory byte address; word = bytes [a..a+3], a is most significant
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE; all acks, errs, mem_en and mem_we = 0; mem_addr, mem_wdata, if_rdata and ld_rdata = 0; last_grant=LOADER, so fetch wins the first tie; lock_cnt=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate, latch the winner's operands into the grant registers, go to ISSUE.
- ISSUE (one cycle):
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the latched operands.
  - Go to RESP.
- RESP (one cycle):
  - Assert the winner's ack; rdata = mem_rdata (passthrough) for reads, 0 for writes.
  - Update last_grant.
  - Re-arbitrate in the same cycle. The requester being acked is excluded, since its req still reads high in this cycle.
  - If the other requester is pending, go to ISSUE with its operands latched. Otherwise go to IDLE.
  - Throughput: one access per 2 cycles; latency from req sampled to ack is 2 cycles.
- Arbitration:
  - Only one requester pending: it wins.
  - Both pending: the one not in last_grant wins.
  - Lock override: when ld_lock=1 and ld_req=1, the loader wins while lock_cnt<LOCK_MAX.
- lock_cnt:
  - Increments on each loader grant made with ld_lock=1.
  - Clears on any fetch grant or when ld_lock=0.
  - At LOCK_MAX with if_req pending, exactly one fetch grant is forced, then the lock resumes.
- Loader re-request after its own RESP: the loader's next request is arbitrated at the following IDLE cycle. Consequence: a locked burst runs at one access per 3 cycles.
- Out-of-range address (addr > MEM_BYTES-4):
  - No memory access; mem_en stays 0 during ISSUE.
  - In RESP: ack=1, err=1, rdata=0.
- No ack is ever asserted to a requester that is not in RESP. Acks are never simultaneous.
- Operand changes while waiting: a requester changing its operands while req is held before ack is a protocol violation. The latched operands are used.
- Request drop: if req drops before it is granted, nothing happens. If it drops after the grant, the access still completes and the ack is still pulsed.
- Reset mid-ISSUE: mem_we and mem_en drop immediately; the write is not guaranteed.

Optional Feature:
- Macro: IMEM_ALIGN_CHECK_EN.
- Defined: an address with addr[1:0]!=0 is treated exactly like out-of-range (no access, err=1).
- Undefined: unaligned addresses access bytes a..a+3 as-is; only the range check applies.

Test Plan:
- After reset, if_req=1, if_addr=0x0, memory bytes 0..3 = 00,00,00,13 -> if_ack at cycle 2, if_rdata=0x00000013, if_err=0.
- ld_we=1, ld_addr=0x10, ld_wdata=0xDEADBEEF, then a fetch at 0x10 -> mem_we for exactly 1 cycle; fetch returns 0xDEADBEEF.
- if_req and ld_req asserted together and held continuously -> acks alternate fetch, loader, fetch, loader, with the first ack to fetch; ack pulses 2 cycles apart.
- ld_lock=1 with 20 back-to-back loader writes while if_req is held -> 16 loader acks, then 1 fetch ack, then the loader resumes.
- if_addr=0x1FE -> if_ack with if_err=1, if_rdata=0, and mem_en never asserted. With IMEM_ALIGN_CHECK_EN defined, if_addr=0x6 -> same error response.
- rst_n pulled low during ISSUE of a write -> mem_en, mem_we and acks are 0 immediately; state is IDLE after release.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and memory-macro signals around imem_arbiter.
// slave = arbiter side, master = requester/memory side.
interface imem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_lock;
  logic              ld_ack;
  logic [31:0]       ld_rdata;
  logic              ld_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rdata,
    output if_ack, if_rdata, if_err, ld_ack, ld_rdata, ld_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rdata,
    input  if_ack, if_rdata, if_err, ld_ack, ld_rdata, ld_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the instruction memory between fetch and loader.
// Define IMEM_ALIGN_CHECK_EN to also reject addresses with addr[1:0] != 0.
module imem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 512,
  parameter int LOCK_MAX  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  imem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_reg, state_next;
  logic              g_ld_reg, g_ld_next;
  logic              g_we_reg, g_we_next;
  logic              g_err_reg, g_err_next;
  logic [ADDR_W-1:0] g_addr_reg, g_addr_next;
  logic [31:0]       g_wdata_reg, g_wdata_next;
  logic              last_ld_reg, last_ld_next;
  logic [CNT_W-1:0]  lock_cnt_reg, lock_cnt_next;

  logic fetch_req, load_req, grant, pick_ld, lock_open;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic bad;
    bad = (a > ADDR_W'(MEM_BYTES - 4));
`ifdef IMEM_ALIGN_CHECK_EN
    bad = bad | (a[1:0] != 2'b00);
`endif
    return bad;
  endfunction

  assign lock_open = bus.ld_lock && (lock_cnt_reg < CNT_W'(LOCK_MAX));

  // Arbitration; in RESP the requester being acked is masked out
  always_comb begin
    fetch_req = bus.if_req;
    load_req  = bus.ld_req;
    if (state_reg == RESP) begin
      if (g_ld_reg) begin
        load_req = 1'b0;
        // a locked burst keeps fetch out until the lock budget is spent
        if (lock_open) fetch_req = 1'b0;
      end else begin
        fetch_req = 1'b0;
      end
    end
    grant = fetch_req | load_req;
    if (load_req && lock_open)      pick_ld = 1'b1;
    else if (fetch_req && load_req) pick_ld = ~last_ld_reg;
    else                            pick_ld = load_req;
  end

  always_comb begin
    state_next    = state_reg;
    g_ld_next     = g_ld_reg;
    g_we_next     = g_we_reg;
    g_err_next    = g_err_reg;
    g_addr_next   = g_addr_reg;
    g_wdata_next  = g_wdata_reg;
    last_ld_next  = last_ld_reg;
    lock_cnt_next = lock_cnt_reg;

    case (state_reg)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP: begin
        last_ld_next = g_ld_reg;
        state_next   = grant ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase

    if ((state_reg == IDLE || state_reg == RESP) && grant) begin
      g_ld_next = pick_ld;
      if (pick_ld) begin
        g_we_next    = bus.ld_we;
        g_addr_next  = bus.ld_addr;
        g_wdata_next = bus.ld_wdata;
        g_err_next   = addr_bad(bus.ld_addr);
      end else begin
        g_we_next    = 1'b0;
        g_addr_next  = bus.if_addr;
        g_wdata_next = 32'h0;
        g_err_next   = addr_bad(bus.if_addr);
      end
      if (!pick_ld)
        lock_cnt_next = '0;
      else if (bus.ld_lock && lock_cnt_reg < CNT_W'(LOCK_MAX))
        lock_cnt_next = lock_cnt_reg + CNT_W'(1);
    end
    if (!bus.ld_lock) lock_cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      g_ld_reg     <= 1'b0;
      g_we_reg     <= 1'b0;
      g_err_reg    <= 1'b0;
      g_addr_reg   <= '0;
      g_wdata_reg  <= 32'h0;
      last_ld_reg  <= 1'b1;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      g_ld_reg     <= g_ld_next;
      g_we_reg     <= g_we_next;
      g_err_reg    <= g_err_next;
      g_addr_reg   <= g_addr_next;
      g_wdata_reg  <= g_wdata_next;
      last_ld_reg  <= last_ld_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // Outputs decode straight from state so reset clears them immediately
  assign bus.mem_en    = (state_reg == ISSUE) && !g_err_reg;
  assign bus.mem_we    = bus.mem_en && g_we_reg;
  assign bus.mem_addr  = g_addr_reg;
  assign bus.mem_wdata = g_wdata_reg;

  assign bus.if_ack   = (state_reg == RESP) && !g_ld_reg;
  assign bus.if_err   = bus.if_ack && g_err_reg;
  assign bus.if_rdata = (bus.if_ack && !g_err_reg) ? bus.mem_rdata : 32'h0;

  assign bus.ld_ack   = (state_reg == RESP) && g_ld_reg;
  assign bus.ld_err   = bus.ld_ack && g_err_reg;
  assign bus.ld_rdata = (bus.ld_ack && !g_err_reg && !g_we_reg) ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized self-checking bench for imem_arbiter with a behavioural memory macro
// and a byte-array reference model of memory contents.
`timescale 1ns/1ps
module tb_imem_arbiter;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 512;
  localparam int LOCK_MAX  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  imem_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [MEM_BYTES];
  logic [7:0] mdl [MEM_BYTES];
  int n_vec = 0;
  int n_err = 0;

  // memory macro: synchronous read, write at the edge while en&we
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_addr <= 32'(MEM_BYTES - 4)) begin
      int a;
      a = int'(bus.mem_addr);
      bus.mem_rdata <= {mem[a], mem[a+1], mem[a+2], mem[a+3]};
      if (bus.mem_we) begin
        mem[a]   <= bus.mem_wdata[31:24];
        mem[a+1] <= bus.mem_wdata[23:16];
        mem[a+2] <= bus.mem_wdata[15:8];
        mem[a+3] <= bus.mem_wdata[7:0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    logic b;
    b = (a > 32'(MEM_BYTES - 4));
`ifdef IMEM_ALIGN_CHECK_EN
    b = b | (a[1:0] != 2'b00);
`endif
    return b;
  endfunction

  function automatic logic [31:0] mdl_word(input logic [31:0] a);
    int i;
    if (bad_addr(a)) return 32'h0;
    i = int'(a);
    return {mdl[i], mdl[i+1], mdl[i+2], mdl[i+3]};
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
    int i;
    if (!bad_addr(a)) begin
      i = int'(a);
      mdl[i] = d[31:24]; mdl[i+1] = d[23:16]; mdl[i+2] = d[15:8]; mdl[i+3] = d[7:0];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 7) return 32'($urandom_range(0, MEM_BYTES - 1));
    if (s < 9) return 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 8));
    return $urandom;
  endfunction

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0;
    bus.ld_wdata = 32'h0; bus.ld_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // waits for the selected ack; counts cycles, mem_en and mem_we cycles seen
  task automatic wait_ack(input bit ld, output int cyc, output int en_cnt, output int we_cnt);
    logic got;
    cyc = 0; en_cnt = 0; we_cnt = 0; got = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_en) en_cnt++;
      if (bus.mem_we) we_cnt++;
      got = ld ? bus.ld_ack : bus.if_ack;
    end
    if (!got) check(ld ? "ld_ack_timeout" : "if_ack_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, en_c, we_c;
    int seq [64];
    int acyc [64];
    int na, nl, nf_burst, first_f, lc1, lc2;
    logic [31:0] la;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_busy, l_busy, l_we;
    int          f_wait, l_wait;

    bus.mem_rdata = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom);
      mdl[i] = mem[i];
    end
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h13;
    mdl[0] = 8'h00; mdl[1] = 8'h00; mdl[2] = 8'h00; mdl[3] = 8'h13;

    // reset values
    idle_inputs();
    @(negedge clk);
    check("rst_acks_errs", {28'h0, bus.if_ack, bus.ld_ack, bus.if_err, bus.ld_err}, 32'h0);
    check("rst_mem_strobes", {30'h0, bus.mem_en, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_rdata", bus.if_rdata | bus.ld_rdata, 32'h0);
    do_reset();

    // first fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    wait_ack(1'b0, cyc, en_c, we_c);
    check("fetch0_latency", 32'(cyc), 32'd2);
    check("fetch0_rdata", bus.if_rdata, 32'h0000_0013);
    check("fetch0_err", 32'(bus.if_err), 32'd0);
    check("fetch0_no_ld_ack", 32'(bus.ld_ack), 32'd0);
    $display("txn fetch addr=%08h rdata=%08h err=%0b", 32'h0, bus.if_rdata, bus.if_err);
    bus.if_req = 1'b0;

    // loader write then fetch it back
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h10; bus.ld_wdata = 32'hDEAD_BEEF;
    wait_ack(1'b1, cyc, en_c, we_c);
    check("ldwr_we_cycles", 32'(we_c), 32'd1);
    check("ldwr_latency", 32'(cyc), 32'd2);
    check("ldwr_err_rdata", {bus.ld_rdata[30:0], bus.ld_err}, 32'h0);
    $display("txn load-write addr=%08h wdata=%08h err=%0b", 32'h10, 32'hDEAD_BEEF, bus.ld_err);
    mdl_write(32'h10, 32'hDEAD_BEEF);
    bus.ld_req = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    wait_ack(1'b0, cyc, en_c, we_c);
    check("fetch10_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    $display("txn fetch addr=%08h rdata=%08h err=%0b", 32'h10, bus.if_rdata, bus.if_err);
    bus.if_req = 1'b0;

    // both requesters held: strict alternation starting with fetch
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h10;
    na = 0; cyc = 0;
    while (na < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.if_ack && bus.ld_ack) check("alt_simultaneous", 32'd1, 32'd0);
      if (bus.if_ack) begin
        check("alt_fetch_rdata", bus.if_rdata, mdl_word(32'h0));
        seq[na] = 0; acyc[na] = cyc; na++;
      end else if (bus.ld_ack) begin
        check("alt_load_rdata", bus.ld_rdata, mdl_word(32'h10));
        seq[na] = 1; acyc[na] = cyc; na++;
      end
    end
    check("alt_ack_count", 32'(na), 32'd8);
    check("alt_first_fetch", 32'(seq[0]), 32'd0);
    for (int k = 1; k < na; k++) begin
      check("alt_order", 32'(seq[k]), 32'(1 - seq[k-1]));
      check("alt_gap", 32'(acyc[k] - acyc[k-1]), 32'd2);
    end
    idle_inputs();
    repeat (6) @(negedge clk);

    // locked burst of 20 writes with fetch held
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.ld_lock = 1'b1; bus.ld_req = 1'b1; bus.ld_we = 1'b1;
    la = 32'($urandom_range(4, 127) * 4);
    bus.ld_addr = la; bus.ld_wdata = $urandom;
    na = 0; nl = 0; nf_burst = 0; first_f = -1; cyc = 0; lc1 = 0; lc2 = 0;
    while (nl < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.ld_ack) begin
        mdl_write(bus.ld_addr, bus.ld_wdata);
        seq[na] = 1; na++; nl++;
        if (nl == 1) lc1 = cyc;
        if (nl == 2) lc2 = cyc;
        if (nl < 20) begin
          la = 32'($urandom_range(4, 127) * 4);
          bus.ld_addr = la; bus.ld_wdata = $urandom;
        end else begin
          bus.ld_req = 1'b0;
        end
      end
      if (bus.if_ack) begin
        check("lock_fetch_rdata", bus.if_rdata, mdl_word(32'h0));
        if (first_f < 0) first_f = na;
        seq[na] = 0; na++; nf_burst++;
      end
    end
    check("lock_loader_acks", 32'(nl), 32'd20);
    check("lock_first_fetch_pos", 32'(first_f), 32'(LOCK_MAX));
    check("lock_fetch_in_burst", 32'(nf_burst), 32'd1);
    check("lock_loader_resumes", 32'(seq[LOCK_MAX+1]), 32'd1);
    check("lock_burst_gap", 32'(lc2 - lc1), 32'd3);
    idle_inputs();
    repeat (6) @(negedge clk);

    // out-of-range (and misaligned when checked) addresses
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h1FE;
    wait_ack(1'b0, cyc, en_c, we_c);
    check("oor_fetch_err", 32'(bus.if_err), 32'd1);
    check("oor_fetch_rdata", bus.if_rdata, 32'h0);
    check("oor_fetch_mem_en", 32'(en_c), 32'd0);
    bus.if_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h1FD; bus.ld_wdata = 32'hA5A5_A5A5;
    wait_ack(1'b1, cyc, en_c, we_c);
    check("oor_load_err", 32'(bus.ld_err), 32'd1);
    check("oor_load_mem_we", 32'(we_c), 32'd0);
    bus.ld_req = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
    bus.if_req = 1'b1; bus.if_addr = 32'h6;
    wait_ack(1'b0, cyc, en_c, we_c);
    check("unaligned_err", 32'(bus.if_err), 32'd1);
    check("unaligned_rdata", bus.if_rdata, 32'h0);
    check("unaligned_mem_en", 32'(en_c), 32'd0);
    bus.if_req = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // randomized traffic from both requesters
    do_reset();
    f_busy = 1'b0; l_busy = 1'b0; f_wait = 0; l_wait = 0;
    f_addr = '0; l_addr = '0; l_wdata = '0; l_we = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      check("one_ack_at_a_time", 32'(bus.if_ack & bus.ld_ack), 32'd0);
      if (bus.if_ack) begin
        check("if_ack_expected", 32'(f_busy), 32'd1);
        check("rnd_if_rdata", bus.if_rdata, mdl_word(f_addr));
        check("rnd_if_err", 32'(bus.if_err), 32'(bad_addr(f_addr)));
        $display("txn fetch addr=%08h rdata=%08h err=%0b", f_addr, bus.if_rdata, bus.if_err);
        f_busy = 1'b0;
      end
      if (bus.ld_ack) begin
        check("ld_ack_expected", 32'(l_busy), 32'd1);
        check("rnd_ld_rdata", bus.ld_rdata, l_we ? 32'h0 : mdl_word(l_addr));
        check("rnd_ld_err", 32'(bus.ld_err), 32'(bad_addr(l_addr)));
        $display("txn load-%s addr=%08h data=%08h err=%0b", l_we ? "write" : "read",
                 l_addr, l_we ? l_wdata : bus.ld_rdata, bus.ld_err);
        if (l_we) mdl_write(l_addr, l_wdata);
        l_busy = 1'b0;
      end
      if (f_busy) f_wait++;
      if (l_busy) l_wait++;
      if (f_wait > 200 || l_wait > 200) begin
        check("rnd_starvation", 32'd1, 32'd0);
        break;
      end
      if (!f_busy) begin
        bus.if_req = ($urandom_range(0, 2) == 0);
        if (bus.if_req) begin
          f_addr = rand_addr(); bus.if_addr = f_addr; f_busy = 1'b1; f_wait = 0;
        end
      end
      if (!l_busy) begin
        bus.ld_req = ($urandom_range(0, 2) == 0);
        bus.ld_lock = ($urandom_range(0, 3) == 0);
        if (bus.ld_req) begin
          l_addr = rand_addr(); l_we = 1'($urandom); l_wdata = $urandom;
          bus.ld_addr = l_addr; bus.ld_we = l_we; bus.ld_wdata = l_wdata;
          l_busy = 1'b1; l_wait = 0;
        end
      end
    end
    idle_inputs();
    repeat (6) @(negedge clk);

    // reset asserted during ISSUE of a write
    do_reset();
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h20; bus.ld_wdata = 32'h1234_5678;
    @(negedge clk);
    check("issue_mem_we", 32'(bus.mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_strobes", {30'h0, bus.mem_en, bus.mem_we}, 32'h0);
    check("midrst_acks", {30'h0, bus.if_ack, bus.ld_ack}, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    en_c = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_en || bus.if_ack || bus.ld_ack) en_c++;
    end
    check("post_rst_quiet", 32'(en_c), 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    wait_ack(1'b0, cyc, en_c, we_c);
    check("post_rst_latency", 32'(cyc), 32'd2);
    check("post_rst_rdata", bus.if_rdata, mdl_word(32'h0));
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
